// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types for the instruction cache: the machine word,
//            the address split (tag / index / byte offset) and the cache
//            frame layout for the default 16-set configuration.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Address split for the default 16-frame direct-mapped cache.
    localparam int IBYT_W = 2;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = WORD_W - IIDX_W - IBYT_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, read-only instruction cache, one word per frame.
//            Hits return combinationally in the request cycle; a miss moves
//            to MISS and holds a fill request until memory drops iwait.
// Ports    : CLK, nRST (async, active-low)
//            imemREN/imemaddr -> ihit/imemload   datapath fetch side
//            iREN/iaddr <- iwait/iload           memory_control fill side
//            hit_count/miss_count                saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CPUID = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = WORD_W - c_IDX_W - IBYT_W;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_MISS = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;

    logic [SETS-1:0]    r_valid;
    logic [c_TAG_W-1:0] r_tag  [SETS];
    word_t              r_data [SETS];

    word_t              r_miss_addr;
    word_t              r_hit_count;
    word_t              r_miss_count;

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic [c_IDX_W-1:0] w_miss_idx;
    logic [c_TAG_W-1:0] w_miss_tag;
    logic               w_hit;
    logic               w_miss_start;
    logic               w_fill;

    // Byte offset is never used for selection; the core index is purely
    // informational. Both are folded here so they are visibly consumed.
    logic               w_unused;
    assign w_unused = &{1'b0, imemaddr[1:0], CPUID[0]};

    assign w_idx      = imemaddr[c_IDX_W+IBYT_W-1:IBYT_W];
    assign w_tag      = imemaddr[WORD_W-1:c_IDX_W+IBYT_W];
    assign w_miss_idx = r_miss_addr[c_IDX_W+IBYT_W-1:IBYT_W];
    assign w_miss_tag = r_miss_addr[WORD_W-1:c_IDX_W+IBYT_W];

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state and outputs
    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        w_miss_start = 1'b0;
        w_fill       = 1'b0;
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;
        case (r_state)
            c_IDLE: begin
                w_hit = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
                ihit  = w_hit;
                if (w_hit) imemload = r_data[w_idx];
                if (imemREN && !w_hit) begin
                    w_miss_start = 1'b1;
                    w_state_next = c_MISS;
                end
            end
            c_MISS: begin
                // The fill runs to completion on the latched address no
                // matter what the datapath does meanwhile.
                iREN  = 1'b1;
                iaddr = r_miss_addr;
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Miss address is stored word-aligned so iaddr never carries byte bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)             r_miss_addr <= '0;
        else if (w_miss_start) r_miss_addr <= {imemaddr[WORD_W-1:IBYT_W], {IBYT_W{1'b0}}};
    end

    // Frames live in flip-flops so reset clears every valid bit at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
            for (int i = 0; i < SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_fill) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_tag[w_miss_idx]   <= w_miss_tag;
            r_data[w_miss_idx]  <= iload;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + 32'd1;
            if (w_miss_start && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Self-checking bench for icache. Directed fetch sequences push
//            the expected hit data into a scoreboard queue; a monitor pops
//            and compares whenever the cache reports a hit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          r_checks;
    int          r_fails;
    logic [31:0] r_expq [$];

    icache #(.SETS(16), .CPUID(0)) u_dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every reported hit must match the oldest expectation.
    always @(negedge CLK) begin
        if (nRST && ihit) begin
            if (r_expq.size() == 0) begin
                r_checks++;
                r_fails++;
                $display("FAIL unexpected_hit: got imemload=%h expected no hit", imemload);
            end else begin
                chk("hit_data", imemload, r_expq.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_check(input logic [31:0] exp_hits, input logic [31:0] exp_misses);
        imemREN = 1'b0;
        @(negedge CLK);
        chk("idle_ihit",   {31'd0, ihit}, 32'd0);
        chk("idle_iren",   {31'd0, iREN}, 32'd0);
        chk("idle_iaddr",  iaddr,         32'd0);
        chk("hit_count",   hit_count,     exp_hits);
        chk("miss_count",  miss_count,    exp_misses);
        next_cycle();
    endtask

    task automatic hit_fetch(input logic [31:0] addr, input logic [31:0] data);
        imemREN  = 1'b1;
        imemaddr = addr;
        r_expq.push_back(data);
        @(negedge CLK);
        chk("hit_ihit",  {31'd0, ihit}, 32'd1);
        chk("hit_iren",  {31'd0, iREN}, 32'd0);
        chk("hit_iaddr", iaddr,         32'd0);
        next_cycle();
    endtask

    // Miss detect cycle, nwait busy cycles, fill cycle, then optionally the
    // hit cycle. imemaddr may be switched to new_addr at busy cycle sw_at.
    task automatic miss_fetch(input logic [31:0] addr, input logic [31:0] aligned,
                              input logic [31:0] data, input int nwait,
                              input int sw_at, input logic [31:0] new_addr,
                              input bit do_hit);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = 32'h0;
        @(negedge CLK);
        chk("detect_ihit", {31'd0, ihit}, 32'd0);
        chk("detect_iren", {31'd0, iREN}, 32'd0);
        next_cycle();
        for (int i = 0; i < nwait; i++) begin
            if (i == sw_at) imemaddr = new_addr;
            @(negedge CLK);
            chk("wait_iren",  {31'd0, iREN}, 32'd1);
            chk("wait_iaddr", iaddr,         aligned);
            chk("wait_ihit",  {31'd0, ihit}, 32'd0);
            next_cycle();
        end
        iwait = 1'b0;
        iload = data;
        @(negedge CLK);
        chk("fill_iren",  {31'd0, iREN}, 32'd1);
        chk("fill_iaddr", iaddr,         aligned);
        next_cycle();
        iwait = 1'b1;
        iload = 32'h0;
        if (do_hit) hit_fetch(imemaddr, data);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_checks = 0;
        r_fails  = 0;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit",     {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload,      32'd0);
        chk("rst_iren",     {31'd0, iREN}, 32'd0);
        chk("rst_iaddr",    iaddr,         32'd0);
        chk("rst_hits",     hit_count,     32'd0);
        chk("rst_misses",   miss_count,    32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        idle_check(32'd0, 32'd0);

        // Cold miss on 0x40, then hits on the cached word
        miss_fetch(32'h0000_0040, 32'h0000_0040, 32'h2008_0001, 0, -1, 32'h0, 1'b1);
        idle_check(32'd1, 32'd1);
        hit_fetch(32'h0000_0040, 32'h2008_0001);
        hit_fetch(32'h0000_0040, 32'h2008_0001);
        idle_check(32'd3, 32'd1);

        // Unaligned hit on the same word
        hit_fetch(32'h0000_0043, 32'h2008_0001);

        // Conflict: 0x443 shares index 0 with 0x40, fill address aligned
        miss_fetch(32'h0000_0443, 32'h0000_0440, 32'hDEAD_0440, 1, -1, 32'h0, 1'b1);
        idle_check(32'd5, 32'd2);
        miss_fetch(32'h0000_0040, 32'h0000_0040, 32'h2008_0001, 0, -1, 32'h0, 1'b1);
        idle_check(32'd6, 32'd3);

        // Long wait with the fetch address switched mid-fill
        miss_fetch(32'h0000_0100, 32'h0000_0100, 32'h1111_0100, 5, 2, 32'h0000_0200, 1'b0);
        miss_fetch(32'h0000_0200, 32'h0000_0200, 32'h2222_0200, 0, -1, 32'h0, 1'b1);
        idle_check(32'd7, 32'd5);

        // Reset during a pending fill
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        iwait    = 1'b1;
        next_cycle();
        @(negedge CLK);
        chk("rmiss_iren_before", {31'd0, iREN}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("rmiss_iren_async",  {31'd0, iREN}, 32'd0);
        chk("rmiss_iaddr_async", iaddr,         32'd0);
        imemREN = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        idle_check(32'd0, 32'd0);

        // After reset the previously cached 0x200 must miss
        miss_fetch(32'h0000_0200, 32'h0000_0200, 32'h2222_0200, 0, -1, 32'h0, 1'b1);
        idle_check(32'd1, 32'd1);

        chk("scoreboard_empty", r_expq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
